// File: rtl/clocked_video_stream_rx_pkg.sv
// Shared types and default widths for the clocked-video stream receiver.
package clocked_video_stream_pkg;

    localparam int CVS_DATA_W = 32;
    localparam int CVS_DIM_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP,
        FLUSH
    } cvs_state_t;

    typedef struct packed {
        logic [CVS_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
    } cvs_entry_t;

endpackage

// File: rtl/clocked_video_stream_rx_if.sv
// Clocked-video input bundle plus the Avalon-ST video output bundle.
interface clocked_video_stream_rx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] vid_data;
    logic              vid_datavalid;
    logic              vid_h_sync;
    logic              vid_v_sync;
    logic              st_ready;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_sop;
    logic              st_eop;

    // Video source and stream sink side
    modport master (
        output vid_data, vid_datavalid, vid_h_sync, vid_v_sync, st_ready,
        input  st_data, st_valid, st_sop, st_eop
    );

    // Receiver side
    modport slave (
        input  vid_data, vid_datavalid, vid_h_sync, vid_v_sync, st_ready,
        output st_data, st_valid, st_sop, st_eop
    );
endinterface

// File: rtl/clocked_video_stream_rx_fifo.sv
// Single-clock first-word-fall-through FIFO; push and pop may coincide when full.
module clocked_video_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, data only
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/clocked_video_stream_rx.sv
// Clocked-video receiver: re-packetises pixels into an SOP/EOP stream and
// measures the active width/height of each frame.
module clocked_video_stream_rx
    import clocked_video_stream_pkg::*;
#(
    parameter int DATA_W     = CVS_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int DIM_W      = CVS_DIM_W
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    clocked_video_stream_rx_if.slave vid,
    output logic [DIM_W-1:0]         frame_width,
    output logic [DIM_W-1:0]         frame_height,
    output logic                     res_valid,
    output logic                     overflow,
    input  logic                     clear_overflow
);
    logic [DATA_W-1:0] data_q;
    logic dv_q, hs_q, vs_q, dv_qq, hs_qq, vs_qq;
    logic vs_rise, dv_fall, hs_rise;

    cvs_state_t state_q, state_d;
    logic sop_pend_q, sop_pend_d, stg_vld_q, stg_vld_d, stg_sop_q, stg_sop_d;
    logic [DATA_W-1:0] stg_data_q, stg_data_d;
    logic ovf_q, ovf_d, ovf_set;

    logic push, pop, fifo_full, fifo_empty, can_push;
    cvs_entry_t push_entry, pop_entry;

    logic [DIM_W-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, last_line_q, last_line_d;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic res_vld_q, res_vld_d;

    function automatic logic [DIM_W-1:0] sat_inc(input logic [DIM_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign vs_rise  = vs_q & ~vs_qq;
    assign dv_fall  = ~dv_q & dv_qq;
    assign hs_rise  = hs_q & ~hs_qq;
    assign pop      = ~fifo_empty & vid.st_ready;
    assign can_push = ~fifo_full | pop;

    // Register the video inputs, then keep a second copy for edge detection
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            data_q <= '0;
            {dv_q, hs_q, vs_q, dv_qq, hs_qq, vs_qq} <= '0;
        end else begin
            data_q <= vid.vid_data;
            dv_q   <= vid.vid_datavalid;
            hs_q   <= vid.vid_h_sync;
            vs_q   <= vid.vid_v_sync;
            dv_qq  <= dv_q;
            hs_qq  <= hs_q;
            vs_qq  <= vs_q;
        end
    end

    // Packetiser state, one-pixel stage and sticky overflow
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            sop_pend_q <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_sop_q  <= 1'b0;
            stg_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sop_pend_q <= sop_pend_d;
            stg_vld_q  <= stg_vld_d;
            stg_sop_q  <= stg_sop_d;
            stg_data_q <= stg_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: the stage is pushed when its successor arrives or the frame ends
    always_comb begin
        state_d    = state_q;
        sop_pend_d = sop_pend_q;
        stg_vld_d  = stg_vld_q;
        stg_sop_d  = stg_sop_q;
        stg_data_d = stg_data_q;
        ovf_set    = 1'b0;
        push       = 1'b0;
        push_entry = '{data: stg_data_q, sop: stg_sop_q, eop: 1'b0};
        case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    state_d    = ACTIVE;
                    sop_pend_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    if (stg_vld_q && !can_push) begin
                        // No room for the closing pixel: hold it and close in FLUSH
                        state_d = FLUSH;
                        ovf_set = dv_q;
                    end else begin
                        push           = stg_vld_q;
                        push_entry.eop = 1'b1;
                        stg_vld_d      = dv_q;
                        stg_data_d     = dv_q ? data_q : stg_data_q;
                        stg_sop_d      = dv_q ? 1'b1 : stg_sop_q;
                        sop_pend_d     = ~dv_q;
                    end
                end else if (dv_q) begin
                    if (stg_vld_q && !can_push) begin
                        ovf_set = 1'b1;
                        state_d = DROP;
                    end else begin
                        push       = stg_vld_q;
                        stg_vld_d  = 1'b1;
                        stg_data_d = data_q;
                        stg_sop_d  = sop_pend_q;
                        sop_pend_d = 1'b0;
                    end
                end
            end
            DROP: begin
                if (vs_rise) state_d = FLUSH;
            end
            FLUSH: begin
                ovf_set = dv_q;
                if (can_push) begin
                    push           = 1'b1;
                    push_entry.eop = 1'b1;
                    stg_vld_d      = 1'b0;
                    state_d        = ACTIVE;
                    sop_pend_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_set | (ovf_q & ~clear_overflow);
    end

    // Frame measurement registers
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            last_line_q <= '0;
            width_q     <= '0;
            height_q    <= '0;
            res_vld_q   <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            last_line_q <= last_line_d;
            width_q     <= width_d;
            height_q    <= height_d;
            res_vld_q   <= res_vld_d;
        end
    end

    // Count pixels per line and lines per frame; latch them on each frame start
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        last_line_d = last_line_q;
        width_d     = width_q;
        height_d    = height_q;
        res_vld_d   = res_vld_q;
        if (state_q != IDLE) begin
            if (dv_q) pix_cnt_d = sat_inc(pix_cnt_q);
            if (dv_fall) begin
                last_line_d = pix_cnt_q;
                line_cnt_d  = sat_inc(line_cnt_q);
                pix_cnt_d   = '0;
            end else if (hs_rise && !dv_q && !dv_qq) begin
                pix_cnt_d = '0;
            end
            if (vs_rise) begin
                if (line_cnt_d != '0) begin
                    width_d   = last_line_d;
                    height_d  = line_cnt_d;
                    res_vld_d = 1'b1;
                end
                line_cnt_d = '0;
                pix_cnt_d  = {{(DIM_W-1){1'b0}}, dv_q};
            end
        end
    end

    clocked_video_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(cvs_entry_t))
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (pop_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign vid.st_valid  = ~fifo_empty;
    assign vid.st_data   = fifo_empty ? '0 : pop_entry.data;
    assign vid.st_sop    = ~fifo_empty & pop_entry.sop;
    assign vid.st_eop    = ~fifo_empty & pop_entry.eop;
    assign frame_width   = width_q;
    assign frame_height  = height_q;
    assign res_valid     = res_vld_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_clocked_video_stream_rx.sv
// Directed and randomized bench for the clocked-video stream receiver.
`timescale 1ns/1ps
module tb_clocked_video_stream_rx;
    localparam int DATA_W = 32, FIFO_DEPTH = 16, DIM_W = 12;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1, clear_overflow = 1'b0;
    logic [DIM_W-1:0] frame_width, frame_height;
    logic res_valid, overflow;

    clocked_video_stream_rx_if #(.DATA_W(DATA_W)) bus();

    clocked_video_stream_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIM_W(DIM_W)) dut (
        .clk_clk(clk), .reset_reset(rst), .vid(bus),
        .frame_width(frame_width), .frame_height(frame_height),
        .res_valid(res_valid), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int errors = 0, checks = 0, cyc = 0, rdy_mode = 1;
    int exp_w = 0, exp_h = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the next expected beat
    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst && bus.st_valid && bus.st_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL beat_extra: observed=%0h expected=none", {bus.st_data, bus.st_sop, bus.st_eop});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", {bus.st_data, bus.st_sop, bus.st_eop}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        case (rdy_mode)
            0: bus.st_ready = 1'b0;
            1: bus.st_ready = 1'b1;
            2: bus.st_ready = ~bus.st_ready;
            default: bus.st_ready = (cyc % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic drive(input logic dv, input logic [DATA_W-1:0] d, input logic vs);
        bus.vid_datavalid = dv;
        bus.vid_data      = d;
        bus.vid_v_sync    = vs;
        tick();
    endtask

    task automatic send_line(input int w, input int base, input int gap);
        for (int i = 0; i < w; i++) drive(1'b1, DATA_W'(base + i), 1'b0);
        for (int g = 0; g < gap; g++) begin
            bus.vid_h_sync = (g == 2);
            drive(1'b0, '0, 1'b0);
        end
        bus.vid_h_sync = 1'b0;
    endtask

    task automatic vs_gap();
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic expect_frame(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{DATA_W'(base + i), i == 0, i == n - 1});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        repeat (2) tick();
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed=%0d outstanding beats expected=0", tag, exp_q.size());
        end
    endtask

    initial begin
        logic [DATA_W-1:0] pix[$];
        int widths[4];
        int h, base;
        bus.vid_data = '0; bus.vid_datavalid = 1'b0; bus.vid_h_sync = 1'b0;
        bus.vid_v_sync = 1'b0; bus.st_ready = 1'b0;

        // Reset values
        #12;
        check("rst_st_valid", bus.st_valid, 0);
        check("rst_st_sop", bus.st_sop, 0);
        check("rst_st_eop", bus.st_eop, 0);
        check("rst_st_data", bus.st_data, 0);
        check("rst_width", frame_width, 0);
        check("rst_height", frame_height, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // 4x3 frame with ready held high
        rdy_mode = 1;
        vs_gap();
        expect_frame(0, 12);
        for (int l = 0; l < 3; l++) send_line(4, 4 * l, 6);
        vs_gap();
        wait_drain("drain_4x3", 200);
        check("width_4x3", frame_width, 4);
        check("height_4x3", frame_height, 3);
        check("res_valid_4x3", res_valid, 1);

        // Same frame with ready toggling
        rdy_mode = 2;
        expect_frame(20, 12);
        for (int l = 0; l < 3; l++) send_line(4, 20 + 4 * l, 6);
        vs_gap();
        wait_drain("drain_toggle", 200);
        check("ovf_toggle", overflow, 0);
        check("height_toggle", frame_height, 3);

        // Backpressure overflow: 16 in FIFO plus the stage survive
        rdy_mode = 0;
        expect_frame(100, FIFO_DEPTH + 1);
        send_line(20, 100, 6);
        check("ovf_set", overflow, 1);
        check("st_valid_full", bus.st_valid, 1);
        vs_gap();
        repeat (3) tick();
        rdy_mode = 1;
        wait_drain("drain_trunc", 200);
        check("width_trunc", frame_width, 20);
        check("height_trunc", frame_height, 1);
        check("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        tick();
        check("ovf_cleared", overflow, 0);

        // Frame start coincident with a pixel
        expect_frame(200, 6);
        expect_frame(250, 3);
        send_line(3, 200, 6);
        send_line(3, 203, 6);
        drive(1'b1, 250, 1'b1);
        drive(1'b1, 251, 1'b1);
        drive(1'b1, 252, 1'b0);
        for (int g = 0; g < 6; g++) drive(1'b0, '0, 1'b0);
        check("width_coinc_a", frame_width, 3);
        check("height_coinc_a", frame_height, 2);
        vs_gap();
        wait_drain("drain_coinc", 200);
        check("height_coinc_b", frame_height, 1);

        // Reset in the middle of a frame
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, DATA_W'(500 + i), 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("st_valid_prerst", bus.st_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("st_valid_midrst", bus.st_valid, 0);
        check("res_valid_midrst", res_valid, 0);
        tick();
        rst = 1'b0;
        rdy_mode = 1;
        send_line(3, 550, 4);
        vs_gap();
        expect_frame(300, 4);
        send_line(2, 300, 6);
        send_line(2, 302, 6);
        vs_gap();
        wait_drain("drain_postrst", 200);
        check("width_postrst", frame_width, 2);
        check("height_postrst", frame_height, 2);
        check("res_valid_postrst", res_valid, 1);

        // Overflow set wins over a coincident clear
        rdy_mode = 0;
        expect_frame(400, FIFO_DEPTH + 1);
        for (int i = 0; i < 19; i++) begin
            clear_overflow = (i == 18);
            drive(i < 18, DATA_W'(400 + i), 1'b0);
        end
        clear_overflow = 1'b0;
        for (int g = 0; g < 4; g++) drive(1'b0, '0, 1'b0);
        check("ovf_set_beats_clear", overflow, 1);
        clear_overflow = 1'b1;
        drive(1'b0, '0, 1'b0);
        clear_overflow = 1'b0;
        drive(1'b0, '0, 1'b0);
        check("ovf_clear_nodrop", overflow, 0);
        vs_gap();
        rdy_mode = 1;
        wait_drain("drain_ovf2", 200);
        check("width_ovf2", frame_width, 18);
        exp_w = 18;
        exp_h = 1;

        // Random frames, ragged lines, random backpressure
        rdy_mode = 3;
        for (int f = 0; f < 8; f++) begin
            h = $urandom_range(0, 4);
            pix.delete();
            for (int l = 0; l < h; l++) begin
                widths[l] = $urandom_range(1, 8);
                for (int i = 0; i < widths[l]; i++) pix.push_back($urandom);
            end
            for (int i = 0; i < pix.size(); i++)
                exp_q.push_back('{pix[i], i == 0, i == pix.size() - 1});
            base = 0;
            for (int l = 0; l < h; l++) begin
                for (int i = 0; i < widths[l]; i++) drive(1'b1, pix[base + i], 1'b0);
                base += widths[l];
                for (int g = 0; g < 12; g++) begin
                    bus.vid_h_sync = (g == 3);
                    drive(1'b0, '0, 1'b0);
                end
                bus.vid_h_sync = 1'b0;
            end
            vs_gap();
            wait_drain("drain_rand", 300);
            if (h > 0) begin
                exp_w = widths[h-1];
                exp_h = h;
            end
            check("width_rand", frame_width, 64'(exp_w));
            check("height_rand", frame_height, 64'(exp_h));
        end
        check("ovf_rand", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clocked_video_stream_rx.md
Name: clocked_video_stream_rx

Overview:
- Receiver for the clocked-video format driven by the VIP clocked-video output: 32-bit pixel, datavalid, active-high h_sync/v_sync.
- Re-packetises the pixels into an Avalon-ST video stream with SOP/EOP and backpressure.
- Measures the active width and height of each frame, and flags overflow.
- Sits in the FPGA fabric as a loopback/capture path for checking the frame-buffer output, in the video clock domain.

Parameters:
- DATA_W, 32, pixel width.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.
- DIM_W, 12, width of the dimension counters (max 4095).

Ports:
- clk_clk  in  1  video clock (the single clock)
- reset_reset  in  1  asynchronous, active-high reset
- vid_data  in  DATA_W  pixel data
- vid_datavalid  in  1  pixel qualifier
- vid_h_sync  in  1  horizontal sync, active high
- vid_v_sync  in  1  vertical sync, active high
- st_ready  in  1  downstream ready
- st_data  out  DATA_W  stream pixel
- st_valid  out  1  stream valid
- st_sop  out  1  first pixel of frame
- st_eop  out  1  last pixel of frame
- frame_width  out  DIM_W  datavalid pixels in last line of previous frame
- frame_height  out  DIM_W  active lines in previous frame
- res_valid  out  1  dimensions latched at least once
- overflow  out  1  sticky: a pixel was dropped
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - All outputs 0, FIFO empty, stage register empty, counters 0, state IDLE.
  - Reset mid-frame discards the partial frame; no EOP is emitted for it.
- Input stage: every vid_* input is registered once. All edge detection uses the registered copy against a second delayed copy.
- vs_rise = rising edge of v_sync. dv_fall = falling edge of datavalid, which ends a line.
- One-pixel stage register {data, sop} holds the newest accepted pixel. This is required because EOP is only known at the next vs_rise.
- Pushes and FIFO:
  - At most one FIFO push per cycle.
  - FIFO is first-word-fall-through. st_valid = FIFO not empty; a pop happens on st_valid && st_ready.
  - A simultaneous push and pop are legal when full or empty.
- State machine:
  - IDLE: ignore pixels. On vs_rise go to ACTIVE with sop_pending=1.
  - ACTIVE: an accepted pixel replaces the stage; its sop = sop_pending, then sop_pending is cleared. If the stage was occupied, the old stage is pushed with eop=0.
  - ACTIVE, vs_rise with the stage occupied: push the stage with eop=1 and set sop_pending=1.
    - If a pixel is accepted in the same cycle, it becomes the new stage with sop=1 and belongs to the new frame.
    - vs_rise with an empty stage (zero-pixel frame) pushes nothing.
  - ACTIVE, push required while the FIFO is full (and no pop this cycle): drop the incoming pixel, keep the stage, set overflow, go to DROP.
  - DROP: discard all pixels. On vs_rise go to FLUSH.
  - FLUSH: push the stage with eop=1 as soon as the FIFO has space, then go to ACTIVE with sop_pending=1. Pixels arriving while in FLUSH are dropped, and overflow is set if any arrive.
  - Every emitted packet therefore ends with exactly one EOP. A truncated frame still carries its EOP.
- Latency: a pixel on the input at cycle n is staged at n+2. It is pushed when the next pixel arrives or at vs_rise. st_valid rises the cycle after the push.
- Measurement:
  - pix_cnt counts accepted datavalid pixels and saturates at 2^DIM_W-1.
  - On dv_fall: last_line = pix_cnt, line_cnt increments (saturating), pix_cnt clears.
  - On vs_rise: if line_cnt>0, latch frame_width=last_line and frame_height=line_cnt, and set res_valid=1. Then clear line_cnt and pix_cnt.
  - Counting continues in DROP and FLUSH; it is independent of the FIFO.
- Overflow: set dominates clear_overflow in the same cycle.
- h_sync is used only as a line boundary for lines without datavalid. It never increments line_cnt.

Decomposition:
- Package clocked_video_stream_pkg: state enum {IDLE, ACTIVE, DROP, FLUSH}, default DATA_W and DIM_W constants, FIFO entry struct {data, sop, eop}.
- Sub-module clocked_video_stream_fifo: single-clock first-word-fall-through FIFO with full/empty flags, parameterised by depth and entry width.

Test Plan:
- Reset, then vs_rise and a 4x3 frame (4 pixels per line, 3 lines, pixel values 0..11), then vs_rise, with st_ready=1 -> 12 beats 0..11; sop on beat 0, eop on beat 11; frame_width=4, frame_height=3, res_valid=1.
- Same frame with st_ready toggling every cycle -> identical data/sop/eop sequence, no overflow, no loss.
- st_ready=0 with FIFO_DEPTH=16 and a 20-pixel frame -> first 17 pixels retained (16 in FIFO plus the stage); overflow=1; after vs_rise and ready, the packet ends with eop on pixel 16; the next frame starts with sop.
- vs_rise coincident with a datavalid pixel -> the previous frame's last pixel carries eop, and the coincident pixel is emitted with sop.
- Reset asserted mid-frame after 5 pixels -> st_valid=0 immediately; pixels before the next vs_rise are ignored; the next frame starts with sop; no orphan eop.
- clear_overflow pulsed in the same cycle as a new drop -> overflow stays 1; a later clear with no drop -> overflow=0.
